// File: rtl/uart_rx_buffer_pkg.sv
// Shared UART constants and the receive-queue entry layout.
// The TX-side buffer and the register-map block import these as well.
package uart_rx_buffer_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_RXQ_ENTRY_W   = 9;
    localparam int UART_RXQ_BREAK_BIT = 8;

    // Break flag sits in the MSB so it lines up with UART_RXQ_BREAK_BIT.
    typedef struct packed {
        logic                   brk;
        logic [UART_DATA_W-1:0] data;
    } rxq_entry_t;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Receiver-facing strobe and consumer-facing valid/ready signals of the RX buffer.
// The buffer takes the slave view; the receiver/consumer side takes the master view.
interface uart_rx_buffer_if;
    import uart_rx_buffer_pkg::*;

    logic                   recv_valid;
    logic [UART_DATA_W-1:0] recv_data;
    logic                   recv_break;
    logic                   out_valid;
    logic                   out_ready;
    logic [UART_DATA_W-1:0] out_data;
    logic                   out_break;

    modport slave (
        input  recv_valid,
        input  recv_data,
        input  recv_break,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_break
    );

    modport master (
        output recv_valid,
        output recv_data,
        output recv_break,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_break
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// Register-array storage: one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset; pointer state elsewhere decides what is valid.
module uart_fifo_mem #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive byte FIFO between the UART receiver and the CPU side, with show-ahead
// head output, occupancy level, threshold interrupt, sticky overflow and flush.
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int THRESH     = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    uart_rx_buffer_if.slave       rxIf,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  irq_thresh,
    output logic                  overflow,
    input  logic                  overflow_clr,
    input  logic                  flush
);

    localparam int                    DEPTH      = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL   = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_THRESH = (DEPTH_LOG2+1)'(THRESH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  irq_q, irq_d;

    logic                        isEmpty;
    logic                        isFull;
    logic                        popEn;
    logic                        pushEn;
    logic                        dropEv;
    logic                        memWe;
    rxq_entry_t                  memWdata;
    logic [UART_RXQ_ENTRY_W-1:0] memRdata;

    always_comb begin
        isEmpty    = (level_q == '0);
        isFull     = (level_q == LVL_FULL);
        popEn      = !isEmpty && rxIf.out_ready;
        // A full queue still accepts a byte when the head leaves on the same edge.
        pushEn     = rxIf.recv_valid && (!isFull || popEn);
        dropEv     = rxIf.recv_valid && isFull && !popEn;

        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        level_d    = level_q;
        memWe      = 1'b0;
        memWdata   = '{brk: rxIf.recv_break, data: rxIf.recv_data};

        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
        end else begin
            memWe = pushEn;
            if (pushEn) begin
                wrPtr_d = wrPtr_q + PTR_ONE;
            end
            if (popEn) begin
                rdPtr_d = rdPtr_q + PTR_ONE;
            end
            if (pushEn && !popEn) begin
                level_d = level_q + LVL_ONE;
            end else if (popEn && !pushEn) begin
                level_d = level_q - LVL_ONE;
            end
        end

        // Set beats clear; a push discarded by flush is not a drop.
        if (dropEv && !flush) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        irq_d = (level_d >= LVL_THRESH);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (UART_RXQ_ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (memWe),
        .waddr (wrPtr_q),
        .wdata (memWdata),
        .raddr (rdPtr_q),
        .rdata (memRdata)
    );

    assign rxIf.out_valid = !isEmpty;
    assign rxIf.out_data  = isEmpty ? '0 : memRdata[UART_DATA_W-1:0];
    assign rxIf.out_break = isEmpty ? 1'b0 : memRdata[UART_RXQ_BREAK_BIT];

    assign level      = level_q;
    assign irq_thresh = irq_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: stimulus queues expected entries, a negedge
// monitor checks every popped head entry; status outputs are checked inline.
module tb_uart_rx_buffer;

    logic       clk;
    logic       resetn;
    logic [4:0] level;
    logic       irq_thresh;
    logic       overflow;
    logic       overflow_clr;
    logic       flush;

    int         total;
    int         bad;
    logic [8:0] expQ [$];

    uart_rx_buffer_if rxIf ();

    uart_rx_buffer #(
        .DEPTH_LOG2 (4),
        .THRESH     (8)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rxIf         (rxIf.slave),
        .level        (level),
        .irq_thresh   (irq_thresh),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .flush        (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total = total + 1;
        if (actual != expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs starting at posedge+1, return at the next posedge+1.
    task automatic applyStimulus(input logic rv, input logic [7:0] d, input logic brk,
                                 input logic rdy, input logic fl, input logic clr,
                                 input logic expPush);
        rxIf.recv_valid = rv;
        rxIf.recv_data  = d;
        rxIf.recv_break = brk;
        rxIf.out_ready  = rdy;
        flush           = fl;
        overflow_clr    = clr;
        if (fl) expQ.delete();
        if (expPush) expQ.push_back({brk, d});
        @(posedge clk);
        #1;
        rxIf.recv_valid = 1'b0;
        rxIf.recv_data  = 8'h00;
        rxIf.recv_break = 1'b0;
        rxIf.out_ready  = 1'b0;
        flush           = 1'b0;
        overflow_clr    = 1'b0;
    endtask

    // Monitor: every accepted head entry must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resetn && rxIf.out_valid && rxIf.out_ready) begin
            if (expQ.size() == 0) begin
                total = total + 1;
                bad   = bad + 1;
                $display("[TB] FAIL pop_unexpected: got 0x%0h, wanted no entry",
                         {rxIf.out_break, rxIf.out_data});
            end else begin
                logic [8:0] exp;
                exp = expQ.pop_front();
                checkOutput("pop_entry", int'({rxIf.out_break, rxIf.out_data}), int'(exp));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, wanted $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total           = 0;
        bad             = 0;
        resetn          = 1'b0;
        rxIf.recv_valid = 1'b0;
        rxIf.recv_data  = 8'h00;
        rxIf.recv_break = 1'b0;
        rxIf.out_ready  = 1'b0;
        flush           = 1'b0;
        overflow_clr    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_level", int'(level), 0);
        checkOutput("rst_out_valid", int'(rxIf.out_valid), 0);
        checkOutput("rst_out_data", int'(rxIf.out_data), 0);
        checkOutput("rst_out_break", int'(rxIf.out_break), 0);
        checkOutput("rst_irq", int'(irq_thresh), 0);
        checkOutput("rst_overflow", int'(overflow), 0);
        resetn = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Single byte: visible the cycle after the strobe, then popped.
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("single_out_valid", int'(rxIf.out_valid), 1);
        checkOutput("single_out_data", int'(rxIf.out_data), 'hA5);
        checkOutput("single_level", int'(level), 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("single_drained_level", int'(level), 0);
        checkOutput("single_drained_data", int'(rxIf.out_data), 0);
        checkOutput("single_drained_valid", int'(rxIf.out_valid), 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("ready_when_empty_level", int'(level), 0);

        // Fill to 16, threshold rises with level 8, 17th byte dropped.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 6) checkOutput("irq_below_thresh", int'(irq_thresh), 0);
            if (i == 7) checkOutput("irq_at_thresh", int'(irq_thresh), 1);
        end
        checkOutput("full_level", int'(level), 16);
        checkOutput("full_overflow_clear", int'(overflow), 0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_overflow", int'(overflow), 1);
        checkOutput("drop_level", int'(level), 16);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 7) checkOutput("irq_level8_after_pops", int'(irq_thresh), 1);
            if (i == 8) checkOutput("irq_fall_level7", int'(irq_thresh), 0);
        end
        checkOutput("drain_level", int'(level), 0);
        checkOutput("drain_overflow_sticky", int'(overflow), 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("overflow_cleared", int'(overflow), 0);

        // Full with simultaneous push and pop: accepted, wraps around.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("pushpop_full_level", int'(level), 16);
        checkOutput("pushpop_full_overflow", int'(overflow), 0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("wrap_last_data", int'(rxIf.out_data), 'h55);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_drained_level", int'(level), 0);

        // Break entry then a normal byte.
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("break_out_break", int'(rxIf.out_break), 1);
        checkOutput("break_out_data", int'(rxIf.out_data), 0);
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("normal_out_break", int'(rxIf.out_break), 0);
        checkOutput("normal_out_data", int'(rxIf.out_data), 'h41);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Overflow set and clear on the same cycle: set wins.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("race_overflow_set", int'(overflow), 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("race_overflow_clr", int'(overflow), 0);

        // Flush while full with a concurrent byte: discarded push is not a drop.
        applyStimulus(1'b1, 8'hDD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_full_level", int'(level), 0);
        checkOutput("flush_full_overflow", int'(overflow), 0);
        checkOutput("flush_full_irq", int'(irq_thresh), 0);

        // Flush with 5 entries and a concurrent byte, overflow preset to 1.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, 1'b0, i < 16);
        end
        checkOutput("preflush_overflow", int'(overflow), 1);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("preflush_level", int'(level), 5);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_level", int'(level), 0);
        checkOutput("flush_out_valid", int'(rxIf.out_valid), 0);
        checkOutput("flush_overflow_kept", int'(overflow), 1);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("postflush_level", int'(level), 1);
        checkOutput("postflush_data", int'(rxIf.out_data), 'h77);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-operation.
        applyStimulus(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("midrst_level", int'(level), 0);
        checkOutput("midrst_out_valid", int'(rxIf.out_valid), 0);
        checkOutput("midrst_overflow", int'(overflow), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
